// File: rtl/adc_pkg.sv
// Shared types and parameter limits for the ADC oversampling block.
// Holds the accumulator FSM state type and the legal LOG2_N range.
package adc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int LOG2_N_MIN = 1;
  localparam int LOG2_N_MAX = 4;

endpackage

// File: rtl/valid_edge_detect.sv
// Rising-edge detector for the ADC sample strobe; edge output is combinational (0 cycles).
// No backpressure: a held-high strobe produces one edge, and a strobe high at reset release counts once.
module valid_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_edge
);

  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev <= 1'b0;
    end else begin
      prev <= in_valid;
    end
  end

  assign in_edge = in_valid & ~prev;

endmodule

// File: rtl/adc_oversampler.sv
// Averages groups of 2**LOG2_N ADC samples and reports mean/min/max; result valid 1 cycle after the Nth sample.
// Result is held until out_ready; a sample arriving while held without out_ready is dropped and flags overrun.
module adc_oversampler
  import adc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LOG2_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic             overrun
);

  localparam int SW = WIDTH + LOG2_N;

  if (LOG2_N < LOG2_N_MIN || LOG2_N > LOG2_N_MAX) begin : g_bad_log2_n
    $error("adc_oversampler: LOG2_N outside legal range");
  end

  state_t            state;
  logic [LOG2_N-1:0] count;
  logic [SW-1:0]     sum;
  logic [WIDTH-1:0]  run_min;
  logic [WIDTH-1:0]  run_max;
  logic              sample_edge;
  logic [SW-1:0]     sum_next;
  logic [WIDTH-1:0]  min_next;
  logic [WIDTH-1:0]  max_next;
  logic              last_sample;

  valid_edge_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_edge  (sample_edge)
  );

  // Sum is WIDTH+LOG2_N wide, so N full-scale samples cannot wrap.
  always_comb begin
    sum_next    = sum + SW'(in_data);
    min_next    = (in_data < run_min) ? in_data : run_min;
    max_next    = (in_data > run_max) ? in_data : run_max;
    last_sample = (count == {LOG2_N{1'b1}});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACCUM;
      count     <= '0;
      sum       <= '0;
      run_min   <= '0;
      run_max   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_min   <= '0;
      out_max   <= '0;
      overrun   <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      count     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (sample_edge) begin
            // First sample of a group overwrites stale running values.
            if (count == '0) begin
              sum     <= SW'(in_data);
              run_min <= in_data;
              run_max <= in_data;
            end else begin
              sum     <= sum_next;
              run_min <= min_next;
              run_max <= max_next;
            end
            if (last_sample) begin
              out_data  <= sum_next[SW-1:LOG2_N];
              out_min   <= min_next;
              out_max   <= max_next;
              out_valid <= 1'b1;
              state     <= HOLD;
              count     <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
            // A sample coinciding with the handshake opens the next group.
            if (sample_edge) begin
              sum     <= SW'(in_data);
              run_min <= in_data;
              run_max <= in_data;
              count   <= LOG2_N'(1);
            end else begin
              count <= '0;
            end
          end else if (sample_edge) begin
            overrun <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_oversampler.sv
// Scoreboard bench for adc_oversampler: a queue-based group model predicts results, a monitor checks them.
module tb_adc_oversampler;

  localparam int WIDTH  = 8;
  localparam int LOG2_N = 2;
  localparam int N      = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             clear     = 1'b0;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic             overrun;

  always #5 clk = ~clk;

  adc_oversampler #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_min   (out_min),
    .out_max   (out_max),
    .overrun   (overrun)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] mn;
    logic [7:0] mx;
  } res_t;

  res_t exp_q[$];
  int   grp[$];
  bit   m_prev, m_hold, m_over;
  int   tests, fails, res_cnt, vcnt;
  int   last_d, last_mn, last_mx;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t group_result();
    res_t r;
    int s, mn, mx;
    s = 0; mn = 255; mx = 0;
    foreach (grp[i]) begin
      s += grp[i];
      if (grp[i] < mn) mn = grp[i];
      if (grp[i] > mx) mx = grp[i];
    end
    r.d  = 8'(s / N);
    r.mn = 8'(mn);
    r.mx = 8'(mx);
    return r;
  endfunction

  // Reference model: state after each rising clock edge, from the inputs seen there.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_prev = 1'b0; m_hold = 1'b0; m_over = 1'b0;
        grp.delete();
        exp_q.delete();
      end else begin
        bit e;
        e = in_valid && !m_prev;
        m_prev = in_valid;
        if (clear) begin
          m_hold = 1'b0; m_over = 1'b0;
          grp.delete();
          exp_q.delete();
        end else if (m_hold) begin
          if (out_ready) begin
            m_hold = 1'b0;
            if (e) grp.push_back(int'(in_data));
          end else if (e) begin
            m_over = 1'b1;
          end
        end else if (e) begin
          grp.push_back(int'(in_data));
          if (grp.size() == N) begin
            exp_q.push_back(group_result());
            grp.delete();
            m_hold = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compares outputs mid-cycle, pops an expectation on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_min", out_min, 0);
        check("reset_out_max", out_max, 0);
        check("reset_overrun", overrun, 0);
      end else begin
        check("out_valid", out_valid, m_hold);
        check("overrun", overrun, m_over);
        if (out_valid) begin
          vcnt++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got out_valid=1 data=%0d, expected no pending result", out_data);
          end else begin
            check("out_data", out_data, exp_q[0].d);
            check("out_min", out_min, exp_q[0].mn);
            check("out_max", out_max, exp_q[0].mx);
            if (out_ready) begin
              last_d = out_data; last_mn = out_min; last_mx = out_max;
              res_cnt++;
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic drive(input bit v, input int d, input bit rdy, input bit clr);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_data   = d[7:0];
    out_ready = rdy;
    clear     = clr;
  endtask

  task automatic pulse(input int d, input bit rdy);
    drive(1'b1, d, rdy, 1'b0);
    drive(1'b0, d, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 0, rdy, 1'b0);
  endtask

  task automatic check_last(input string name, input int d, input int mn, input int mx);
    check({name, "_data"}, last_d, d);
    check({name, "_min"}, last_mn, mn);
    check({name, "_max"}, last_mx, mx);
  endtask

  initial begin
    int r0, v0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    idle(2, 1'b1);

    // Basic average with a single valid cycle
    r0 = res_cnt; v0 = vcnt;
    pulse(10, 1'b1); pulse(20, 1'b1); pulse(30, 1'b1); pulse(41, 1'b1);
    idle(3, 1'b1);
    check("basic_results", res_cnt - r0, 1);
    check("basic_valid_cycles", vcnt - v0, 1);
    check_last("basic", 25, 10, 41);

    // Full-scale samples must not wrap
    for (int i = 0; i < 4; i++) pulse(255, 1'b1);
    idle(3, 1'b1);
    check_last("fullscale", 255, 255, 255);

    // Overrun while holding, then a fresh group
    pulse(1, 1'b0); pulse(2, 1'b0); pulse(3, 1'b0); pulse(4, 1'b0);
    idle(3, 1'b0);
    check("hold_valid", out_valid, 1);
    check("hold_no_overrun", overrun, 0);
    pulse(7, 1'b0);
    idle(2, 1'b0);
    check("overrun_set", overrun, 1);
    check("overrun_hold_data", out_data, 2);
    check("overrun_hold_min", out_min, 1);
    check("overrun_hold_max", out_max, 4);
    idle(1, 1'b1);
    pulse(5, 1'b1); pulse(6, 1'b1); pulse(7, 1'b1); pulse(8, 1'b1);
    idle(3, 1'b1);
    check_last("after_overrun", 6, 5, 8);
    check("overrun_sticky", overrun, 1);
    drive(1'b0, 0, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("overrun_cleared", overrun, 0);

    // Edge coincident with the handshake opens the next group
    r0 = res_cnt;
    for (int i = 0; i < 4; i++) pulse(20, 1'b0);
    idle(2, 1'b0);
    pulse(50, 1'b1);
    pulse(50, 1'b1); pulse(50, 1'b1); pulse(50, 1'b1);
    idle(3, 1'b1);
    check("coincident_results", res_cnt - r0, 2);
    check_last("coincident", 50, 50, 50);
    check("coincident_overrun", overrun, 0);

    // Level held high counts once
    r0 = res_cnt;
    for (int i = 0; i < 10; i++) drive(1'b1, 99, 1'b1, 1'b0);
    drive(1'b0, 99, 1'b1, 1'b0);
    pulse(1, 1'b1); pulse(1, 1'b1);
    idle(2, 1'b1);
    check("level_no_early_result", res_cnt - r0, 0);
    pulse(1, 1'b1);
    idle(3, 1'b1);
    check("level_one_result", res_cnt - r0, 1);
    check_last("level", 25, 1, 99);

    // Reset mid-group discards the partial group
    pulse(100, 1'b1); pulse(100, 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_out_data", out_data, 0);
    check("midrst_out_max", out_max, 0);
    check("midrst_out_min", out_min, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) pulse(8, 1'b1);
    idle(3, 1'b1);
    check_last("after_reset", 8, 8, 8);

    // Clear mid-group, with a coincident edge that must be discarded
    pulse(100, 1'b1); pulse(100, 1'b1);
    drive(1'b1, 77, 1'b1, 1'b1);
    drive(1'b0, 77, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pulse(8, 1'b1);
    idle(3, 1'b1);
    check_last("after_clear", 8, 8, 8);

    // in_valid high across reset release counts as one edge
    @(posedge clk);
    #2 rst = 1'b0;
    in_valid = 1'b1; in_data = 8'd60;
    @(posedge clk);
    #2 rst = 1'b1;
    drive(1'b0, 60, 1'b1, 1'b0);
    pulse(4, 1'b1); pulse(4, 1'b1); pulse(4, 1'b1);
    idle(3, 1'b1);
    check_last("release_edge", 18, 4, 60);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 400) == 0) begin
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
      end else begin
        drive($urandom_range(0, 2) != 0, int'($urandom_range(0, 255)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
      end
    end
    idle(5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
